// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and defaults for the IF/MEM single-port memory arbiter.
package mem_port_arbiter_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    WAIT_D = 2'd2,
    WAIT_I = 2'd3
  } state_e;

  localparam logic OWNER_I = 1'b0;
  localparam logic OWNER_D = 1'b1;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one variable-latency memory port between fetch and the MEM stage; data has priority.
// Optional stall statistics counter enabled by MEM_PORT_ARBITER_STATS_EN.
//
// state  | meaning
// IDLE   | no access outstanding; accept data request first, then fetch
// ISSUE  | mem_en strobe cycle; a same-cycle ack completes immediately
// WAIT_D | data access outstanding, waiting for mem_ack
// WAIT_I | fetch access outstanding, waiting for mem_ack
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_done,
  input  logic              d_rd,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_done,
  output logic              stall_mem,
  output logic              stall_if,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [15:0]       stall_cycles
);

  state_e            state_q, state_d;
  logic              owner_q, owner_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_wr_q, mem_wr_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              i_done_q, i_done_d;
  logic              d_done_q, d_done_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    mem_en_d    = 1'b0;
    mem_wr_d    = mem_wr_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    i_done_d    = 1'b0;
    d_done_d    = 1'b0;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;

    case (state_q)
      IDLE: begin
        // A requester still holding a just-completed request must not be re-served.
        if (!(d_done_q || i_done_q)) begin
          if (d_rd || d_wr) begin
            state_d     = ISSUE;
            owner_d     = OWNER_D;
            mem_en_d    = 1'b1;
            mem_wr_d    = d_wr;
            mem_addr_d  = d_addr;
            mem_wdata_d = d_wdata;
          end else if (i_req) begin
            state_d    = ISSUE;
            owner_d    = OWNER_I;
            mem_en_d   = 1'b1;
            mem_wr_d   = 1'b0;
            mem_addr_d = i_addr;
          end
        end
      end
      ISSUE, WAIT_D, WAIT_I: begin
        if (mem_ack) begin
          state_d = IDLE;
          if (owner_q == OWNER_D) begin
            d_done_d = 1'b1;
            if (!mem_wr_q) d_rdata_d = mem_rdata;
          end else begin
            i_done_d  = 1'b1;
            i_rdata_d = mem_rdata;
          end
        end else if (state_q == ISSUE) begin
          state_d = (owner_q == OWNER_D) ? WAIT_D : WAIT_I;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= OWNER_I;
      mem_en_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      i_done_q    <= 1'b0;
      d_done_q    <= 1'b0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      mem_en_q    <= mem_en_d;
      mem_wr_q    <= mem_wr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      i_done_q    <= i_done_d;
      d_done_q    <= d_done_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_wr    = mem_wr_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign i_done    = i_done_q;
  assign d_done    = d_done_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;

  // Stalls release in the done cycle so the pipeline advances exactly once per access.
  assign stall_mem = (d_rd | d_wr) & ~d_done_q;
  assign stall_if  = stall_mem | (i_req & ~i_done_q);

`ifdef MEM_PORT_ARBITER_STATS_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_if && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) stall_cnt_q <= '0;
    else     stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cycles = stall_cnt_q;
`else
  assign stall_cycles = '0;
`endif

endmodule
